opendap_swd_host_serial: RTL and testbench

- Probe-side SWD initiator: the host end of the SW-DP serial link.
- Accepts parallel transfer commands, generates SWCLK, and serialises the header and write data onto SWDIO.
- Samples ACK, read data and parity from the target, and returns one parallel response per command.
- Sits between a debug-host command FIFO and the SWDIO/SWCLK pad cells; used as the bench driver for the DP and in the OpenDAP probe.

---
 rtl/opendap_swd_host_serial_pkg.sv | 44 ++++
 rtl/opendap_swd_host_clkgen.sv | 37 +++
 rtl/opendap_swd_host_serial.sv | 264 ++++++++++++++++++++++++++
 tb/tb_opendap_swd_host_serial.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opendap_swd_host_serial_pkg.sv
// Shared definitions for the SWD host serialiser: ACK codes, command opcodes,
// phase lengths, FSM states and the request-header builder.
package opendap_swd_host_serial_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef enum logic [1:0] {
        OP_XFER       = 2'd0,
        OP_LINE_RESET = 2'd1,
        OP_TARGETSEL  = 2'd2,
        OP_NOP        = 2'd3
    } swd_op_e;

    localparam logic [5:0] HEADER_LEN   = 6'd8;
    localparam logic [5:0] ACK_LEN      = 6'd3;
    localparam logic [5:0] DATA_LEN     = 6'd33;
    localparam logic [5:0] TSEL_GAP_LEN = 6'd5;
    localparam logic [5:0] LRESET_ONES  = 6'd50;
    localparam logic [5:0] LRESET_ZEROS = 6'd2;
    localparam logic [5:0] LRESET_LEN   = LRESET_ONES + LRESET_ZEROS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HEADER,
        S_TURN1,
        S_ACK,
        S_TSEL_GAP,
        S_RDATA,
        S_TURN2,
        S_WDATA,
        S_TAIL,
        S_LRESET
    } swd_state_e;

    // Header byte as sent LSB first: start, APnDP, RnW, A2, A3, parity, stop, park.
    function automatic logic [7:0] swd_header(input logic ap_ndp, input logic r_nw,
                                              input logic [1:0] addr);
        return {1'b1, 1'b0, ap_ndp ^ r_nw ^ addr[0] ^ addr[1], addr[1], addr[0],
                r_nw, ap_ndp, 1'b1};
    endfunction

endpackage

// File: rtl/opendap_swd_host_clkgen.sv
// SWCLK divider: toggles swclk every CLK_DIV clk cycles while enabled and
// flags the clk cycle on which each rising or falling edge is produced.
module opendap_swd_host_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic swclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(CLK_DIV - 1));
    assign rise = en && wrap && !swclk;
    assign fall = en && wrap && swclk;

    // Disabling parks the clock low with the divider cleared, so the first
    // half-period after enable is always a full low phase.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            swclk <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            swclk <= ~swclk;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/opendap_swd_host_serial.sv
// SWD host serialiser: turns parallel commands into SWD line traffic and
// returns one response per command. Optional WAIT auto-retry is built when
// OPENDAP_SWD_HOST_AUTO_RETRY_EN is defined.
module opendap_swd_host_serial
    import opendap_swd_host_serial_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int IDLE_CYCLES = 2,
    parameter int MAX_RETRY   = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        swclk,
    output logic        swdo,
    output logic        swdo_en,
    input  logic        swdi,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_ap_ndp,
    input  logic        cmd_r_nw,
    input  logic [1:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_parity_err,
    output logic        busy
);

    localparam logic [5:0] TAIL_LEN = 6'(IDLE_CYCLES);

    if (CLK_DIV < 1 || IDLE_CYCLES < 0 || IDLE_CYCLES > 63 || MAX_RETRY < 0) begin : g_param_check
        $error("opendap_swd_host_serial: parameter out of range");
    end

    swd_state_e  state_q, state_d, enter_st;
    swd_op_e     op_q, op_d;
    logic        enter;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] sh_q, sh_d;
    logic [32:0] rsh_q, rsh_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rnw_q, rnw_d;
    logic [2:0]  ack_q, ack_d;
    logic        swdo_d, swdo_en_d;
    logic        rsp_valid_d, rsp_perr_d;
    logic [2:0]  rsp_ack_d;
    logic [31:0] rsp_rdata_d;
    logic        rd_ok;
    logic        rise, fall;

`ifdef OPENDAP_SWD_HOST_AUTO_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
`endif

    opendap_swd_host_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != S_IDLE),
        .swclk(swclk),
        .rise (rise),
        .fall (fall)
    );

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rd_ok     = (op_q == OP_XFER) && rnw_q && (ack_q == ACK_OK);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rsh_d       = rsh_q;
        hdr_d       = hdr_q;
        wdata_d     = wdata_q;
        rnw_d       = rnw_q;
        ack_d       = ack_q;
        swdo_d      = swdo;
        swdo_en_d   = swdo_en;
        rsp_valid_d = 1'b0;
        rsp_ack_d   = rsp_ack;
        rsp_rdata_d = rsp_rdata;
        rsp_perr_d  = rsp_parity_err;
        enter       = 1'b0;
        enter_st    = S_IDLE;
`ifdef OPENDAP_SWD_HOST_AUTO_RETRY_EN
        retry_d     = retry_q;
`endif

        if (rise) begin
            if (state_q == S_ACK)   ack_d = {swdi, ack_q[2:1]};
            if (state_q == S_RDATA) rsh_d = {swdi, rsh_q[32:1]};
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = swd_op_e'(cmd_op);
                    wdata_d = cmd_wdata;
                    rnw_d   = cmd_r_nw;
`ifdef OPENDAP_SWD_HOST_AUTO_RETRY_EN
                    retry_d = '0;
`endif
                    case (op_d)
                        OP_XFER: begin
                            hdr_d    = swd_header(cmd_ap_ndp, cmd_r_nw, cmd_addr);
                            enter    = 1'b1;
                            enter_st = S_HEADER;
                        end
                        OP_TARGETSEL: begin
                            rnw_d    = 1'b0;
                            hdr_d    = swd_header(cmd_ap_ndp, 1'b0, 2'b11);
                            enter    = 1'b1;
                            enter_st = S_HEADER;
                        end
                        OP_LINE_RESET: begin
                            enter    = 1'b1;
                            enter_st = S_LRESET;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_ack_d   = 3'b000;
                            rsp_perr_d  = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                if (fall) begin
                    if (cnt_q != 6'd1) begin
                        cnt_d = cnt_q - 6'd1;
                        sh_d  = sh_q >> 1;
                        if (state_q == S_HEADER || state_q == S_WDATA) swdo_d = sh_q[1];
                        else if (state_q == S_LRESET) swdo_d = (cnt_q - 6'd1) > LRESET_ZEROS;
                    end else begin
                        enter = 1'b1;
                        case (state_q)
                            S_HEADER:   enter_st = (op_q == OP_TARGETSEL) ? S_TSEL_GAP : S_TURN1;
                            S_TURN1:    enter_st = S_ACK;
                            S_ACK:      enter_st = (ack_q == ACK_OK && rnw_q) ? S_RDATA : S_TURN2;
                            S_TSEL_GAP: enter_st = S_WDATA;
                            S_RDATA:    enter_st = S_TURN2;
                            S_TURN2:    enter_st = (ack_q == ACK_OK && !rnw_q) ? S_WDATA : S_TAIL;
                            S_WDATA:    enter_st = S_TAIL;
                            default:    enter_st = S_IDLE;
                        endcase
                    end
                end
            end
        endcase

        if (enter && enter_st == S_TAIL && TAIL_LEN == 6'd0) enter_st = S_IDLE;

`ifdef OPENDAP_SWD_HOST_AUTO_RETRY_EN
        // A WAIT reissues the stored header instead of completing the command.
        if (enter && enter_st == S_IDLE && op_q == OP_XFER && ack_q == ACK_WAIT
            && retry_q < RW'(MAX_RETRY)) begin
            retry_d  = retry_q + RW'(1);
            enter_st = S_HEADER;
        end
`endif

        if (enter) begin
            state_d = enter_st;
            case (enter_st)
                S_HEADER: begin
                    cnt_d     = HEADER_LEN;
                    sh_d      = {25'd0, hdr_d};
                    swdo_d    = hdr_d[0];
                    swdo_en_d = 1'b1;
                end
                S_TURN1, S_TURN2: begin
                    cnt_d     = 6'd1;
                    swdo_d    = 1'b0;
                    swdo_en_d = 1'b0;
                end
                S_ACK: begin
                    cnt_d     = ACK_LEN;
                    swdo_en_d = 1'b0;
                end
                S_TSEL_GAP: begin
                    cnt_d     = TSEL_GAP_LEN;
                    swdo_d    = 1'b0;
                    swdo_en_d = 1'b0;
                end
                S_RDATA: begin
                    cnt_d     = DATA_LEN;
                    swdo_en_d = 1'b0;
                end
                S_WDATA: begin
                    cnt_d     = DATA_LEN;
                    sh_d      = {^wdata_q, wdata_q};
                    swdo_d    = wdata_q[0];
                    swdo_en_d = 1'b1;
                end
                S_TAIL: begin
                    cnt_d     = TAIL_LEN;
                    swdo_d    = 1'b0;
                    swdo_en_d = 1'b1;
                end
                S_LRESET: begin
                    cnt_d     = LRESET_LEN;
                    swdo_d    = 1'b1;
                    swdo_en_d = 1'b1;
                end
                default: begin
                    swdo_d      = 1'b0;
                    swdo_en_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_ack_d   = (op_q == OP_XFER) ? ack_q : 3'b000;
                    rsp_perr_d  = rd_ok && ((^rsh_q[31:0]) != rsh_q[32]);
                    if (rd_ok) rsp_rdata_d = rsh_q[31:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= OP_XFER;
            cnt_q          <= '0;
            sh_q           <= '0;
            rsh_q          <= '0;
            hdr_q          <= '0;
            wdata_q        <= '0;
            rnw_q          <= 1'b0;
            ack_q          <= '0;
            swdo           <= 1'b0;
            swdo_en        <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_ack        <= '0;
            rsp_rdata      <= '0;
            rsp_parity_err <= 1'b0;
`ifdef OPENDAP_SWD_HOST_AUTO_RETRY_EN
            retry_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            cnt_q          <= cnt_d;
            sh_q           <= sh_d;
            rsh_q          <= rsh_d;
            hdr_q          <= hdr_d;
            wdata_q        <= wdata_d;
            rnw_q          <= rnw_d;
            ack_q          <= ack_d;
            swdo           <= swdo_d;
            swdo_en        <= swdo_en_d;
            rsp_valid      <= rsp_valid_d;
            rsp_ack        <= rsp_ack_d;
            rsp_rdata      <= rsp_rdata_d;
            rsp_parity_err <= rsp_perr_d;
`ifdef OPENDAP_SWD_HOST_AUTO_RETRY_EN
            retry_q        <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_opendap_swd_host_serial.sv
// Bench for opendap_swd_host_serial: a bit-level SWD target model drives swdi,
// the host's line activity is recorded per SWCLK period and compared to a model.
module tb_opendap_swd_host_serial;

    localparam int CLK_DIV     = 2;
    localparam int IDLE_CYCLES = 2;
    localparam int MAX_RETRY   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        swclk, swdo, swdo_en;
    logic        swdi = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_ap_ndp = 1'b0;
    logic        cmd_r_nw = 1'b0;
    logic [1:0]  cmd_addr = 2'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_parity_err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-bit {drive enable, drive value}: expected and observed.
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    logic       plan_q[$];
    logic [2:0] ack_seq_q[$];

    logic [2:0]  exp_ack;
    logic [31:0] exp_rdata;
    logic        exp_perr;

    logic        obs_got, obs_busy, obs_ready, obs_clk_at_rsp, obs_perr;
    logic [2:0]  obs_ack;
    logic [31:0] obs_rdata;
    int          obs_lat, obs_pulses;
    logic        obs_rst_en, obs_rst_clk, obs_rst_busy, obs_rst_valid, obs_rst_ready;

    opendap_swd_host_serial #(
        .CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .swclk(swclk), .swdo(swdo), .swdo_en(swdo_en), .swdi(swdi),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ap_ndp(cmd_ap_ndp), .cmd_r_nw(cmd_r_nw), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata), .rsp_parity_err(rsp_parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_header(input logic apndp, input logic rnw,
                                                input logic [1:0] addr);
        logic [7:0] h;
        h = 8'd0;
        h[0] = 1'b1;
        h[1] = apndp;
        h[2] = rnw;
        h[3] = addr[0];
        h[4] = addr[1];
        h[5] = ((int'(apndp) + int'(rnw) + int'(addr[0]) + int'(addr[1])) % 2) == 1;
        h[7] = 1'b1;
        return h;
    endfunction

    task automatic push_bit(input logic en, input logic val, input logic target);
        exp_q.push_back({en, en ? val : 1'b0});
        plan_q.push_back(target);
    endtask

    task automatic model_xfer(input logic apndp, input logic rnw, input logic [1:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic corrupt);
        logic [7:0] h;
        logic [2:0] a;
        int attempt;
        bit again;
        exp_q.delete(); plan_q.delete();
        h = model_header(apndp, rnw, addr);
        attempt = 0;
        do begin
            a = ack_seq_q[(attempt < ack_seq_q.size()) ? attempt : ack_seq_q.size() - 1];
            for (int i = 0; i < 8; i++) push_bit(1'b1, h[i], 1'b1);
            push_bit(1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) push_bit(1'b0, 1'b0, a[i]);
            if (a == 3'b001 && rnw) begin
                for (int i = 0; i < 32; i++) push_bit(1'b0, 1'b0, rdata[i]);
                push_bit(1'b0, 1'b0, (^rdata) ^ corrupt);
                push_bit(1'b0, 1'b0, 1'b1);
            end else if (a == 3'b001) begin
                push_bit(1'b0, 1'b0, 1'b1);
                for (int i = 0; i < 32; i++) push_bit(1'b1, wdata[i], 1'b1);
                push_bit(1'b1, ^wdata, 1'b1);
            end else begin
                push_bit(1'b0, 1'b0, 1'b1);
            end
            for (int i = 0; i < IDLE_CYCLES; i++) push_bit(1'b1, 1'b0, 1'b1);
`ifdef OPENDAP_SWD_HOST_AUTO_RETRY_EN
            again = (a == 3'b010) && (attempt < MAX_RETRY);
`else
            again = 1'b0;
`endif
            attempt++;
        end while (again);
        exp_ack   = a;
        exp_rdata = rdata;
        exp_perr  = (a == 3'b001) && rnw && corrupt;
    endtask

    function automatic int trace_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] obs_header();
        logic [7:0] h;
        h = 8'd0;
        for (int i = 0; i < 8; i++) if (i < obs_q.size()) h[i] = obs_q[i][0];
        return h;
    endfunction

    // ---------------- driver ----------------
    task automatic do_cmd(input logic [1:0] op, input logic apndp, input logic rnw,
                          input logic [1:0] addr, input logic [31:0] wdata, input int abort_at);
        int idx, lat;
        logic prev;
        idx = 0; lat = 0; prev = 1'b0;
        obs_got = 1'b0; obs_pulses = 0; obs_lat = -1;
        obs_q.delete();
        @(negedge clk);
        obs_ready = cmd_ready;
        swdi = (plan_q.size() > 0) ? plan_q[0] : 1'b1;
        cmd_valid = 1'b1; cmd_op = op; cmd_ap_ndp = apndp; cmd_r_nw = rnw;
        cmd_addr = addr; cmd_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        obs_busy = busy;
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) @(negedge clk);
            if (swclk && !prev) begin
                obs_q.push_back({swdo_en, swdo_en ? swdo : 1'b0});
                idx++;
                swdi = (idx < plan_q.size()) ? plan_q[idx] : 1'b1;
                lat = 0;
            end else begin
                lat++;
            end
            prev = swclk;
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                obs_rst_en = swdo_en; obs_rst_clk = swclk; obs_rst_busy = busy;
                obs_rst_valid = rsp_valid; obs_rst_ready = cmd_ready;
                rst = 1'b0;
                repeat (300) begin
                    @(negedge clk);
                    if (rsp_valid) obs_pulses++;
                end
                return;
            end
            if (rsp_valid) begin
                obs_got = 1'b1; obs_pulses = 1;
                obs_ack = rsp_ack; obs_rdata = rsp_rdata; obs_perr = rsp_parity_err;
                obs_lat = lat; obs_clk_at_rsp = swclk;
                break;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) obs_pulses++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (swclk !== 1'b0) begin n_fail++; $display("FAIL reset_swclk: got %b need 0", swclk); end
        n_cmp++; if (swdo !== 1'b0) begin n_fail++; $display("FAIL reset_swdo: got %b need 0", swdo); end
        n_cmp++; if (swdo_en !== 1'b0) begin n_fail++; $display("FAIL reset_swdo_en: got %b need 0", swdo_en); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
        n_cmp++; if (rsp_ack !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_ack: got %b need 000", rsp_ack); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h need 0", rsp_rdata); end
        n_cmp++; if (rsp_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b need 0", rsp_parity_err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b need 1", cmd_ready); end
        rst = 1'b0;
    endtask

    task automatic check_common(input string tag);
        int d;
        n_cmp++; if (obs_got !== 1'b1) begin n_fail++; $display("FAIL %s_rsp_timeout: got no rsp_valid, need one", tag); end
        n_cmp++; if (obs_pulses != 1) begin n_fail++; $display("FAIL %s_rsp_count: got %0d need 1", tag, obs_pulses); end
        n_cmp++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL %s_ack: got %b need %b", tag, obs_ack, exp_ack); end
        n_cmp++; if (obs_perr !== exp_perr) begin n_fail++; $display("FAIL %s_parity_err: got %b need %b", tag, obs_perr, exp_perr); end
        d = trace_diff();
        n_cmp++; if (d != -1) begin n_fail++; $display("FAIL %s_trace: first diff %0d, got %0d bits need %0d", tag, d, obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_read_dp();
        ack_seq_q = '{3'b001};
        model_xfer(1'b0, 1'b1, 2'b00, 32'd0, 32'h0BC12477, 1'b0);
        do_cmd(2'd0, 1'b0, 1'b1, 2'b00, 32'd0, -1);
        check_common("read_dp");
        n_cmp++; if (obs_header() !== 8'hA5) begin n_fail++; $display("FAIL read_dp_header: got %h need a5", obs_header()); end
        n_cmp++; if (obs_rdata !== 32'h0BC12477) begin n_fail++; $display("FAIL read_dp_rdata: got %h need 0bc12477", obs_rdata); end
        n_cmp++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL read_dp_busy: got %b need 1", obs_busy); end
        n_cmp++; if (obs_lat != CLK_DIV) begin n_fail++; $display("FAIL read_dp_rsp_latency: got %0d need %0d", obs_lat, CLK_DIV); end
        n_cmp++; if (obs_clk_at_rsp !== 1'b0) begin n_fail++; $display("FAIL read_dp_swclk_idle: got %b need 0", obs_clk_at_rsp); end
    endtask

    task automatic test_write_dp();
        ack_seq_q = '{3'b001};
        model_xfer(1'b0, 1'b0, 2'b10, 32'h000000F0, 32'd0, 1'b0);
        do_cmd(2'd0, 1'b0, 1'b0, 2'b10, 32'h000000F0, -1);
        check_common("write_dp");
        n_cmp++; if (obs_header() !== 8'hB1) begin n_fail++; $display("FAIL write_dp_header: got %h need b1", obs_header()); end
        n_cmp++; if (obs_q.size() < 46 || obs_q[45] !== 2'b10) begin n_fail++; $display("FAIL write_dp_parity_bit: got %0d bits, need bit45 driven 0", obs_q.size()); end
    endtask

    task automatic test_line_reset_targetsel();
        exp_q.delete(); plan_q.delete();
        for (int i = 0; i < 50; i++) push_bit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) push_bit(1'b1, 1'b0, 1'b1);
        exp_ack = 3'b000; exp_perr = 1'b0;
        do_cmd(2'd1, 1'b0, 1'b0, 2'b00, 32'd0, -1);
        check_common("line_reset");
        exp_q.delete(); plan_q.delete();
        for (int i = 0; i < 8; i++) push_bit(1'b1, model_header(1'b0, 1'b0, 2'b11) >> i, 1'b1);
        push_bit(1'b0, 1'b0, 1'b1);
        push_bit(1'b0, 1'b0, 1'b1);
        push_bit(1'b0, 1'b0, 1'b0);
        push_bit(1'b0, 1'b0, 1'b0);
        push_bit(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) push_bit(1'b1, (32'h01002927 >> i) & 1, 1'b1);
        push_bit(1'b1, ^32'h01002927, 1'b1);
        for (int i = 0; i < IDLE_CYCLES; i++) push_bit(1'b1, 1'b0, 1'b1);
        exp_ack = 3'b000; exp_perr = 1'b0;
        do_cmd(2'd2, 1'b0, 1'b1, 2'b00, 32'h01002927, -1);
        check_common("targetsel");
        n_cmp++; if (obs_header() !== 8'h99) begin n_fail++; $display("FAIL targetsel_header: got %h need 99", obs_header()); end
    endtask

    task automatic test_wait();
        ack_seq_q = '{3'b010, 3'b010, 3'b010, 3'b001};
        model_xfer(1'b1, 1'b1, 2'b01, 32'd0, 32'hCAFE1234, 1'b0);
        do_cmd(2'd0, 1'b1, 1'b1, 2'b01, 32'd0, -1);
        check_common("wait");
    endtask

    task automatic test_parity_err();
        ack_seq_q = '{3'b001};
        model_xfer(1'b1, 1'b1, 2'b11, 32'd0, 32'h80000001, 1'b1);
        do_cmd(2'd0, 1'b1, 1'b1, 2'b11, 32'd0, -1);
        check_common("parity_err");
        n_cmp++; if (obs_rdata !== 32'h80000001) begin n_fail++; $display("FAIL parity_err_rdata: got %h need 80000001", obs_rdata); end
    endtask

    task automatic test_nop();
        exp_q.delete(); plan_q.delete();
        exp_ack = 3'b000; exp_perr = 1'b0;
        do_cmd(2'd3, 1'b0, 1'b1, 2'b00, 32'd0, -1);
        check_common("nop");
    endtask

    task automatic test_reset_mid();
        ack_seq_q = '{3'b001};
        model_xfer(1'b0, 1'b1, 2'b01, 32'd0, 32'h12345678, 1'b0);
        do_cmd(2'd0, 1'b0, 1'b1, 2'b01, 32'd0, 25);
        n_cmp++; if (obs_rst_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_swdo_en: got %b need 0", obs_rst_en); end
        n_cmp++; if (obs_rst_clk !== 1'b0) begin n_fail++; $display("FAIL mid_rst_swclk: got %b need 0", obs_rst_clk); end
        n_cmp++; if (obs_rst_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b need 0", obs_rst_busy); end
        n_cmp++; if (obs_rst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rsp_valid: got %b need 0", obs_rst_valid); end
        n_cmp++; if (obs_rst_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cmd_ready: got %b need 1", obs_rst_ready); end
        n_cmp++; if (obs_pulses != 0) begin n_fail++; $display("FAIL mid_rst_no_rsp: got %0d pulses need 0", obs_pulses); end
    endtask

    task automatic test_random();
        logic apndp, rnw, corrupt;
        logic [1:0] addr;
        logic [31:0] wd, rd;
        logic [2:0] a;
        for (int n = 0; n < 16; n++) begin
            apndp = 1'($urandom_range(0, 1));
            rnw = 1'($urandom_range(0, 1));
            addr = 2'($urandom_range(0, 3));
            wd = $urandom; rd = $urandom;
            corrupt = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 3'b001;
                1: a = 3'b010;
                2: a = 3'b100;
                default: a = 3'($urandom_range(0, 7));
            endcase
            ack_seq_q = '{a};
            model_xfer(apndp, rnw, addr, wd, rd, corrupt);
            do_cmd(2'd0, apndp, rnw, addr, wd, -1);
            check_common($sformatf("rand%0d", n));
            n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL rand%0d_cmd_ready: got %b need 1", n, obs_ready); end
            if (exp_ack == 3'b001 && rnw) begin
                n_cmp++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL rand%0d_rdata: got %h need %h", n, obs_rdata, exp_rdata); end
            end
            n_cmp++; if (obs_lat != CLK_DIV) begin n_fail++; $display("FAIL rand%0d_rsp_latency: got %0d need %0d", n, obs_lat, CLK_DIV); end
        end
    endtask

    initial begin
        test_reset();
        test_read_dp();
        test_write_dp();
        test_line_reset_targetsel();
        test_wait();
        test_parity_err();
        test_nop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
